// File: rtl/mor1kx_avalon_slave_ram_if.sv
// Avalon-MM bus bundle between the mor1kx master bridge and the RAM slave.
// Direction suffixes follow the slave's point of view.
interface mor1kx_avalon_slave_ram_if;
    logic [31:0] avs_address_i;
    logic [3:0]  avs_byteenable_i;
    logic        avs_read_i;
    logic        avs_write_i;
    logic [31:0] avs_writedata_i;
    logic [3:0]  avs_burstcount_i;
    logic        avs_waitrequest_o;
    logic [31:0] avs_readdata_o;
    logic        avs_readdatavalid_o;

    modport master (
        output avs_address_i, avs_byteenable_i, avs_read_i, avs_write_i,
        output avs_writedata_i, avs_burstcount_i,
        input  avs_waitrequest_o, avs_readdata_o, avs_readdatavalid_o
    );

    modport slave (
        input  avs_address_i, avs_byteenable_i, avs_read_i, avs_write_i,
        input  avs_writedata_i, avs_burstcount_i,
        output avs_waitrequest_o, avs_readdata_o, avs_readdatavalid_o
    );
endinterface

// File: rtl/mor1kx_avalon_slave_ram.sv
// Avalon-MM burst slave over single-port RAM, 1-cycle read latency.
// MOR1KX_AVALON_SLAVE_WRAP_BURST_EN selects wrapping power-of-two bursts.
module mor1kx_avalon_slave_ram #(
    parameter int    ADDR_WIDTH    = 10,
    parameter string MEM_INIT_FILE = ""
) (
    input logic clk,
    input logic rst,
    mor1kx_avalon_slave_ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RBURST = 2'd1;
    localparam logic [1:0] WBURST = 2'd2;

    logic [31:0] mem [DEPTH];

    logic [1:0]            state;
    logic [3:0]            remaining;
    logic [3:0]            beat;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            bc_n;
    logic                  idle;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  bst_rd;
    logic                  bst_wr;
    logic                  re;
    logic                  we;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic                  unused_bits;

    assign req_addr = bus.avs_address_i[ADDR_WIDTH+1:2];
    assign bc_n     = (bus.avs_burstcount_i == 4'd0) ? 4'd1
                                                     : bus.avs_burstcount_i;
    assign unused_bits = ^{bus.avs_address_i[31:ADDR_WIDTH+2],
                           bus.avs_address_i[1:0]};

    assign idle   = (state == IDLE);
    assign acc_wr = idle & ~rst & bus.avs_write_i;
    assign acc_rd = idle & ~rst & bus.avs_read_i & ~bus.avs_write_i;
    assign bst_rd = (state == RBURST) & ~rst;
    assign bst_wr = (state == WBURST) & ~rst & bus.avs_write_i;
    assign re     = acc_rd | bst_rd;
    assign we     = acc_wr | bst_wr;
    assign addr   = idle ? req_addr : beat_addr;

`ifdef MOR1KX_AVALON_SLAVE_WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] nxt_mask;

    always_comb begin
        nxt_mask = '1;
        if (bc_n == 4'd2 || bc_n == 4'd4 || bc_n == 4'd8)
            nxt_mask = ADDR_WIDTH'(bc_n - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (idle)
            wmask <= nxt_mask;
    end

    assign beat_addr = (base & ~wmask)
                     | ((base + ADDR_WIDTH'(beat)) & wmask);
`else
    assign beat_addr = base + ADDR_WIDTH'(beat);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 4'd0;
            beat      <= 4'd0;
            base      <= '0;
            rvalid    <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            rvalid <= re;
            if (re)
                rdata <= mem[addr];
            if (acc_wr | acc_rd) begin
                base      <= req_addr;
                beat      <= 4'd1;
                remaining <= bc_n - 4'd1;
                if (bc_n > 4'd1)
                    state <= acc_wr ? WBURST : RBURST;
            end else if (bst_rd | bst_wr) begin
                beat      <= beat + 4'd1;
                remaining <= remaining - 4'd1;
                if (remaining == 4'd1)
                    state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.avs_byteenable_i[b])
                    mem[addr][8*b +: 8] <= bus.avs_writedata_i[8*b +: 8];
            end
        end
    end

    assign bus.avs_waitrequest_o   = rst | (state == RBURST);
    assign bus.avs_readdata_o      = rdata;
    assign bus.avs_readdatavalid_o = rvalid;
endmodule
